// File: rtl/memory_master_burst.sv
// Command-word driven memory bus master: register setup, single or burst request
// issue with address/ID auto-increment, and a small response FIFO with readback.
module memory_master_burst #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 24,
   parameter int ID_WIDTH   = 8,
   parameter int RESP_DEPTH = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [31:0]           in,
   output logic [31:0]           out,
   output logic [ADDR_WIDTH-1:0] msAddress,
   output logic [DATA_WIDTH-1:0] msData,
   output logic [ID_WIDTH-1:0]   msID,
   output logic                  msWrite,
   output logic                  msValid,
   input  logic                  msTaken,
   input  logic [DATA_WIDTH-1:0] smData,
   input  logic [ID_WIDTH-1:0]   smID,
   input  logic                  smValid,
   output logic                  smTaken
);

   localparam int PW = $clog2(RESP_DEPTH);
   localparam int CW = PW + 1;
   localparam int UW = ADDR_WIDTH - 24;
   localparam int EW = DATA_WIDTH + ID_WIDTH;

   localparam logic [7:0] CMD_ADDR_LOWER  = 8'd1;
   localparam logic [7:0] CMD_ADDR_UPPER  = 8'd2;
   localparam logic [7:0] CMD_DATA        = 8'd3;
   localparam logic [7:0] CMD_ID          = 8'd4;
   localparam logic [7:0] CMD_WRITE       = 8'd5;
   localparam logic [7:0] CMD_SEND        = 8'd6;
   localparam logic [7:0] CMD_GET_PENDING = 8'd7;
   localparam logic [7:0] CMD_GET_DATA    = 8'd8;
   localparam logic [7:0] CMD_GET_ID      = 8'd9;
   localparam logic [7:0] CMD_GET_VALID   = 8'd10;
   localparam logic [7:0] CMD_CLEAR       = 8'd11;
   localparam logic [7:0] CMD_BURST       = 8'd12;
   localparam logic [7:0] CMD_GET_COUNT   = 8'd13;
   localparam logic [7:0] CMD_FLUSH       = 8'd14;

   logic [7:0]            cmd;
   logic [23:0]           field;
   logic [7:0]            prev_cmd;
   logic                  cmd_edge;

   logic [15:0]           remaining;
   logic                  auto_inc;
   logic                  busy;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [ID_WIDTH-1:0]   id_q;
   logic                  write_q;

   logic [EW-1:0]         fifo_mem [RESP_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  push;
   logic                  pop;
   logic                  flush;
   logic [EW-1:0]         head;
   logic [DATA_WIDTH-1:0] head_data;
   logic [ID_WIDTH-1:0]   head_id;

   assign cmd        = in[31:24];
   assign field      = in[23:0];
   assign cmd_edge   = (cmd != prev_cmd);
   assign busy       = (remaining != 16'd0);

   assign fifo_full  = (count == CW'(RESP_DEPTH));
   assign fifo_empty = (count == '0);
   assign flush      = (cmd == CMD_FLUSH);
   assign smTaken    = !fifo_full && !flush;
   assign push       = smValid && smTaken;
   assign pop        = (cmd == CMD_CLEAR) && cmd_edge && !fifo_empty;

   assign msAddress  = addr_q;
   assign msData     = data_q;
   assign msID       = id_q;
   assign msWrite    = write_q;
   assign msValid    = busy;

   always_ff @(posedge clock) begin
      if (reset) begin
         prev_cmd  <= '0;
         remaining <= '0;
         auto_inc  <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         id_q      <= '0;
         write_q   <= 1'b0;
      end else begin
         prev_cmd <= cmd;
         if (!busy) begin
            case (cmd)
               CMD_ADDR_LOWER: addr_q[23:0] <= field;
               CMD_ADDR_UPPER: addr_q[ADDR_WIDTH-1:24] <= field[UW-1:0];
               CMD_DATA:       data_q <= field[DATA_WIDTH-1:0];
               CMD_ID:         id_q <= field[ID_WIDTH-1:0];
               CMD_WRITE:      write_q <= field[0];
               CMD_SEND: begin
                  if (cmd_edge) begin
                     remaining <= 16'd1;
                     auto_inc  <= 1'b0;
                  end
               end
               CMD_BURST: begin
                  if (cmd_edge && field[15:0] != 16'd0) begin
                     remaining <= field[15:0];
                     auto_inc  <= 1'b1;
                  end
               end
               default: ;
            endcase
         end else if (msTaken) begin
            remaining <= remaining - 16'd1;
            if (auto_inc) begin
               addr_q <= addr_q + ADDR_WIDTH'(1);
               id_q   <= id_q + ID_WIDTH'(1);
            end
         end
      end
   end

   // Response FIFO pointers and occupancy; storage itself needs no reset.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr] <= {smData, smID};
   end

   assign head      = fifo_mem[rd_ptr];
   assign head_data = fifo_empty ? '0 : head[EW-1:ID_WIDTH];
   assign head_id   = fifo_empty ? '0 : head[ID_WIDTH-1:0];

   always_comb begin
      out = '0;
      case (cmd)
         CMD_GET_PENDING: out = 32'(remaining);
         CMD_GET_DATA:    out = 32'(head_data);
         CMD_GET_ID:      out = 32'(head_id);
         CMD_GET_VALID:   out = 32'(!fifo_empty);
         CMD_GET_COUNT:   out = 32'(count);
         default:         out = '0;
      endcase
   end

endmodule

// File: tb/tb_memory_master_burst.sv
// Scenario bench for memory_master_burst (48-bit address build): request and
// response scoreboards fed at stimulus time and drained as the DUT produces output.
module tb_memory_master_burst;

   localparam logic [7:0] C_NONE = 8'd0,  C_ALO = 8'd1,  C_AHI = 8'd2,  C_DATA = 8'd3;
   localparam logic [7:0] C_ID   = 8'd4,  C_WR  = 8'd5,  C_SEND = 8'd6, C_PEND = 8'd7;
   localparam logic [7:0] C_GDAT = 8'd8,  C_GID = 8'd9,  C_GVAL = 8'd10, C_CLR = 8'd11;
   localparam logic [7:0] C_BRST = 8'd12, C_GCNT = 8'd13, C_FLSH = 8'd14;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] in;
   logic [31:0] out;
   logic [47:0] msAddress;
   logic [23:0] msData;
   logic [7:0]  msID;
   logic        msWrite, msValid, msTaken;
   logic [23:0] smData;
   logic [7:0]  smID;
   logic        smValid, smTaken;

   int tests = 0;
   int fails = 0;
   logic [80:0] req_q[$];
   logic [80:0] hs_q[$];
   logic [31:0] rsp_q[$];

   memory_master_burst #(.ADDR_WIDTH(48), .DATA_WIDTH(24), .ID_WIDTH(8), .RESP_DEPTH(4)) dut (
      .clock(clock), .reset(reset), .in(in), .out(out),
      .msAddress(msAddress), .msData(msData), .msID(msID), .msWrite(msWrite),
      .msValid(msValid), .msTaken(msTaken),
      .smData(smData), .smID(smID), .smValid(smValid), .smTaken(smTaken)
   );

   initial forever #5 clock = ~clock;

   // Advance one cycle, recording any request handshake at the falling edge.
   task automatic tick();
      @(negedge clock);
      if (!reset && msValid && msTaken) hs_q.push_back({msAddress, msID, msWrite, msData});
      @(posedge clock);
      #1;
   endtask

   task automatic set_reg(input logic [7:0] code, input logic [23:0] f);
      in = {code, f};
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; in = '0; msTaken = 0; smValid = 0; smData = '0; smID = '0;
      tick(); tick();
      reset = 1'b0;
      tests++;
      if ({msValid, smTaken, msAddress, msData, msID, msWrite} !== {1'b0, 1'b1, 48'd0, 24'd0, 8'd0, 1'b0}) begin
         fails++;
         $display("FAIL reset_outputs: got v=%b t=%b a=%h d=%h id=%h w=%b expected v=0 t=1 zeros",
                  msValid, smTaken, msAddress, msData, msID, msWrite);
      end
      in = {C_PEND, 24'd0}; #1;
      tests++;
      if (out !== 32'd0) begin fails++; $display("FAIL reset_pending: got %h expected 0", out); end
      in = {C_GCNT, 24'd0}; #1;
      tests++;
      if (out !== 32'd0) begin fails++; $display("FAIL reset_count: got %h expected 0", out); end
      in = '0;
      tick();
   endtask

   task automatic test_send_single();
      logic [80:0] a, e;
      set_reg(C_ALO, 24'h123456);
      set_reg(C_AHI, 24'h000000);
      set_reg(C_ID, 24'h000005);
      set_reg(C_DATA, 24'h111111);
      set_reg(C_WR, 24'h000000);
      req_q.push_back({48'h000000123456, 8'h05, 1'b0, 24'h111111});
      in = {C_SEND, 24'd0};
      tick();
      tests++;
      if (msValid !== 1'b1) begin fails++; $display("FAIL send_valid: got %b expected 1", msValid); end
      tick();
      msTaken = 1'b1;
      tick();
      msTaken = 1'b0;
      tests++;
      if (msValid !== 1'b0) begin fails++; $display("FAIL send_drop: got %b expected 0", msValid); end
      tick();
      in = {C_NONE, 24'd0};
      tests++;
      if (msValid !== 1'b0 || hs_q.size() != 1) begin
         fails++;
         $display("FAIL send_once: valid=%b handshakes=%0d expected valid=0 handshakes=1", msValid, hs_q.size());
      end
      while (hs_q.size() > 0 && req_q.size() > 0) begin
         a = hs_q.pop_front(); e = req_q.pop_front();
         tests++;
         if (a !== e) begin fails++; $display("FAIL send_req: got %h expected %h", a, e); end
      end
      smValid = 1'b1; smData = 24'hABCDEF; smID = 8'h05;
      rsp_q.push_back({24'hABCDEF, 8'h05});
      tick();
      smValid = 1'b0;
      in = {C_GVAL, 24'd0}; #1;
      tests++;
      if (out !== 32'd1) begin fails++; $display("FAIL send_get_valid: got %h expected 1", out); end
      in = {C_GDAT, 24'd0}; #1;
      tests++;
      if (out !== {8'd0, rsp_q[0][31:8]}) begin fails++; $display("FAIL send_get_data: got %h expected %h", out, rsp_q[0][31:8]); end
      in = {C_GID, 24'd0}; #1;
      tests++;
      if (out !== {24'd0, rsp_q[0][7:0]}) begin fails++; $display("FAIL send_get_id: got %h expected %h", out, rsp_q[0][7:0]); end
      in = {C_CLR, 24'd0};
      tick();
      void'(rsp_q.pop_front());
      in = {C_GVAL, 24'd0}; #1;
      tests++;
      if (out !== 32'd0) begin fails++; $display("FAIL send_clear_valid: got %h expected 0", out); end
      in = '0;
      tick();
   endtask

   task automatic test_burst_wrap();
      logic [80:0] a, e;
      logic [47:0] ea;
      logic [7:0]  ei;
      set_reg(C_ALO, 24'hFFFFFE);
      set_reg(C_AHI, 24'h0000FF);
      set_reg(C_ID, 24'h0000FE);
      set_reg(C_DATA, 24'h5A5A5A);
      set_reg(C_WR, 24'h000001);
      ea = 48'h0000FF_FFFFFE; ei = 8'hFE;
      for (int i = 0; i < 3; i++) begin
         req_q.push_back({ea, ei, 1'b1, 24'h5A5A5A});
         ea = ea + 48'd1; ei = ei + 8'd1;
      end
      msTaken = 1'b1;
      in = {C_BRST, 24'd3};
      tick();
      for (int i = 0; i < 4; i++) begin
         in = {C_PEND, 24'd0}; #1;
         tests++;
         if (out !== 32'(3 - i) || msValid !== (i < 3)) begin
            fails++;
            $display("FAIL burst_pending%0d: got pend=%0d valid=%b expected pend=%0d valid=%b", i, out, msValid, 3 - i, (i < 3));
         end
         if (i < 3) tick();
      end
      msTaken = 1'b0;
      in = '0;
      tests++;
      if (hs_q.size() != 3) begin fails++; $display("FAIL burst_count: got %0d expected 3", hs_q.size()); end
      while (hs_q.size() > 0 && req_q.size() > 0) begin
         a = hs_q.pop_front(); e = req_q.pop_front();
         tests++;
         if (a !== e) begin fails++; $display("FAIL burst_req: got %h expected %h", a, e); end
      end
      tick();
   endtask

   task automatic test_stall();
      logic [80:0] a, e;
      set_reg(C_ALO, 24'h000100);
      set_reg(C_AHI, 24'h000000);
      set_reg(C_ID, 24'h000010);
      req_q.push_back({48'h000000000100, 8'h10, 1'b1, 24'h5A5A5A});
      req_q.push_back({48'h000000000101, 8'h11, 1'b1, 24'h5A5A5A});
      msTaken = 1'b0;
      in = {C_BRST, 24'd2};
      tick();
      for (int c = 0; c < 5; c++) begin
         tests++;
         if (msValid !== 1'b1 || msAddress !== 48'h100) begin
            fails++;
            $display("FAIL stall_hold%0d: got valid=%b addr=%h expected valid=1 addr=100", c, msValid, msAddress);
         end
         if (c == 1) in = {C_ALO, 24'hAAAAAA};
         if (c == 2) in = {C_SEND, 24'd0};
         if (c == 3) in = {C_NONE, 24'd0};
         tick();
      end
      msTaken = 1'b1;
      tick(); tick();
      msTaken = 1'b0;
      tests++;
      if (msValid !== 1'b0 || msAddress !== 48'h102 || msID !== 8'h12) begin
         fails++;
         $display("FAIL stall_end: got valid=%b addr=%h id=%h expected valid=0 addr=102 id=12", msValid, msAddress, msID);
      end
      tests++;
      if (hs_q.size() != 2) begin fails++; $display("FAIL stall_count: got %0d expected 2", hs_q.size()); end
      while (hs_q.size() > 0 && req_q.size() > 0) begin
         a = hs_q.pop_front(); e = req_q.pop_front();
         tests++;
         if (a !== e) begin fails++; $display("FAIL stall_req: got %h expected %h", a, e); end
      end
   endtask

   task automatic test_fifo_full();
      int model_cnt = 0;
      int idx = 0;
      logic exp_taken;
      in = {C_FLSH, 24'd0};
      tick();
      rsp_q.delete();
      in = '0;
      smValid = 1'b1;
      for (int c = 0; c < 7; c++) begin
         smData = 24'hC00000 + 24'(idx); smID = 8'(idx);
         #1;
         exp_taken = (model_cnt < 4);
         tests++;
         if (smTaken !== exp_taken) begin fails++; $display("FAIL full_taken%0d: got %b expected %b", c, smTaken, exp_taken); end
         if (exp_taken) begin
            rsp_q.push_back({smData, smID});
            model_cnt++; idx++;
         end
         tick();
      end
      in = {C_CLR, 24'd0}; #1;
      tests++;
      if (smTaken !== 1'b0) begin fails++; $display("FAIL full_clear_same: got %b expected 0", smTaken); end
      tick();
      void'(rsp_q.pop_front()); model_cnt--;
      in = '0; #1;
      tests++;
      if (smTaken !== 1'b1) begin fails++; $display("FAIL full_after_clear: got %b expected 1", smTaken); end
      rsp_q.push_back({smData, smID}); model_cnt++;
      tick();
      smValid = 1'b0;
      in = {C_GCNT, 24'd0}; #1;
      tests++;
      if (out !== 32'(model_cnt)) begin fails++; $display("FAIL full_count: got %0d expected %0d", out, model_cnt); end
      in = {C_GDAT, 24'd0}; #1;
      tests++;
      if (out !== {8'd0, rsp_q[0][31:8]}) begin fails++; $display("FAIL full_head: got %h expected %h", out, rsp_q[0][31:8]); end
      in = '0;
      tick();
   endtask

   task automatic test_simultaneous();
      in = {C_FLSH, 24'd0};
      tick();
      rsp_q.delete();
      in = '0;
      smValid = 1'b1; smData = 24'h111111; smID = 8'h21;
      rsp_q.push_back({smData, smID});
      tick();
      smData = 24'h222222; smID = 8'h22;
      rsp_q.push_back({smData, smID});
      tick();
      smData = 24'h333333; smID = 8'h23;
      in = {C_CLR, 24'd0}; #1;
      tests++;
      if (smTaken !== 1'b1) begin fails++; $display("FAIL simul_taken: got %b expected 1", smTaken); end
      rsp_q.push_back({smData, smID});
      tick();
      void'(rsp_q.pop_front());
      smValid = 1'b0;
      in = {C_GCNT, 24'd0}; #1;
      tests++;
      if (out !== 32'(rsp_q.size())) begin fails++; $display("FAIL simul_count: got %0d expected %0d", out, rsp_q.size()); end
      in = {C_GDAT, 24'd0}; #1;
      tests++;
      if (out !== {8'd0, rsp_q[0][31:8]}) begin fails++; $display("FAIL simul_head: got %h expected %h", out, rsp_q[0][31:8]); end
      tick();
      in = {C_FLSH, 24'd0}; smValid = 1'b1; smData = 24'h444444; smID = 8'h24; #1;
      tests++;
      if (smTaken !== 1'b0) begin fails++; $display("FAIL flush_taken0: got %b expected 0", smTaken); end
      tick();
      tests++;
      if (smTaken !== 1'b0) begin fails++; $display("FAIL flush_taken1: got %b expected 0", smTaken); end
      tick();
      rsp_q.delete();
      in = '0; smValid = 1'b0;
      in = {C_GCNT, 24'd0}; #1;
      tests++;
      if (out !== 32'd0) begin fails++; $display("FAIL flush_count: got %0d expected 0", out); end
      in = {C_GVAL, 24'd0}; #1;
      tests++;
      if (out !== 32'd0) begin fails++; $display("FAIL flush_valid: got %0d expected 0", out); end
      in = {C_GDAT, 24'd0}; #1;
      tests++;
      if (out !== 32'd0) begin fails++; $display("FAIL empty_head: got %h expected 0", out); end
      in = '0;
      tick();
   endtask

   task automatic test_reset_mid_burst();
      logic [80:0] a, e;
      int cyc = 0;
      smValid = 1'b1; smData = 24'h777777; smID = 8'h77;
      tick();
      smValid = 1'b0;
      set_reg(C_ALO, 24'h000010);
      set_reg(C_ID, 24'h000000);
      for (int i = 0; i < 3; i++) req_q.push_back({48'h10 + 48'(i), 8'(i), 1'b1, 24'h5A5A5A});
      msTaken = 1'b1;
      in = {C_BRST, 24'd10};
      tick();
      while (hs_q.size() < 3 && cyc < 20) begin
         tick();
         cyc++;
      end
      tests++;
      if (hs_q.size() < 3) begin fails++; $display("FAIL rst_burst_timeout: got %0d handshakes expected 3", hs_q.size()); end
      reset = 1'b1; msTaken = 1'b0; in = '0;
      tick();
      reset = 1'b0;
      tests++;
      if (msValid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b expected 0", msValid); end
      in = {C_PEND, 24'd0}; #1;
      tests++;
      if (out !== 32'd0) begin fails++; $display("FAIL rst_pending: got %0d expected 0", out); end
      in = {C_GCNT, 24'd0}; #1;
      tests++;
      if (out !== 32'd0) begin fails++; $display("FAIL rst_count: got %0d expected 0", out); end
      in = '0;
      rsp_q.delete();
      while (hs_q.size() > 0 && req_q.size() > 0) begin
         a = hs_q.pop_front(); e = req_q.pop_front();
         tests++;
         if (a !== e) begin fails++; $display("FAIL rst_req: got %h expected %h", a, e); end
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_send_single();
      test_burst_wrap();
      test_stall();
      test_fifo_full();
      test_simultaneous();
      test_reset_mid_burst();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/memory_master_burst.md
# memory_master_burst

Parametrised, register-command-driven master for the memory bus, used by the soft-processor or debug port to issue memory requests through a single 32-bit command word. It adds four things: configurable address, data and ID widths; burst issue of sequential requests with auto-incrementing address and ID; a multi-entry response FIFO; and edge-triggered SEND, BURST and CLEAR commands. It sits between a 32-bit command/readback register pair and one master port of the memory bus.

## Interface
- ADDR_WIDTH, 32, request address width; legal range 25..48.
- DATA_WIDTH, 24, request/response data width; legal range 1..24.
- ID_WIDTH, 8, transaction ID width; legal range 1..8.
- RESP_DEPTH, 4, response FIFO entries; power of two, at least 2.
- Clock and reset: one clock `clock`; `reset` is synchronous and active-high.
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in  in  32  command word: [31:24] command code, [23:0] field.
- out  out  32  readback, combinational from `in` and state.
- msAddress  out  ADDR_WIDTH  request address.
- msData  out  DATA_WIDTH  write data.
- msID  out  ID_WIDTH  request ID.
- msWrite  out  1  1 = write, 0 = read.
- msValid  out  1  request valid.
- msTaken  in  1  request accepted by the bus.
- smData  in  DATA_WIDTH  response data.
- smID  in  ID_WIDTH  response ID.
- smValid  in  1  response valid.
- smTaken  out  1  response accepted; equals !full && command != FLUSH.

## Operation
- Command codes:
  - 0 NONE
  - 1 ADDRESS_LOWER: addr[23:0] <= field.
  - 2 ADDRESS_UPPER: addr[ADDR_WIDTH-1:24] <= field low bits.
  - 3 DATA: data <= field[DATA_WIDTH-1:0].
  - 4 ID: id <= field[ID_WIDTH-1:0].
  - 5 WRITE: write <= field[0].
  - 6 SEND
  - 7 GET_PENDING
  - 8 GET_DATA
  - 9 GET_ID
  - 10 GET_VALID
  - 11 CLEAR
  - 12 BURST
  - 13 GET_COUNT
  - 14 FLUSH
  - 15..255 behave as NONE.
- Register writes (codes 1-5) act every cycle the code is present. They are ignored while busy (remaining != 0).
- Edge commands: SEND, BURST and CLEAR act only on the first cycle the code appears, i.e. when the previous cycle's command differed. Holding the code does nothing further. The previous-command register resets to NONE.
- SEND start while idle: remaining <= 1, no auto-increment.
- BURST start while idle: remaining <= field[15:0] and auto-increment is enabled. A count of 0 is a no-op.
- SEND or BURST start while busy: ignored.
- Request handshake: occurs on any cycle with msValid && msTaken.
  - remaining decrements.
  - In burst mode, addr <= addr+1 (wraps at 2^ADDR_WIDTH) and id <= id+1 (wraps at 2^ID_WIDTH).
  - msValid stays 1 while remaining > 1, so requests go back-to-back with the updated address and ID.
  - msValid drops when the last request is taken.
- msData and msWrite stay constant across a burst. msAddress, msData, msID and msWrite are driven directly from the registers.
- Response FIFO:
  - Push on smValid && smTaken, storing {smData, smID}.
  - CLEAR pops the head if non-empty; CLEAR on empty does nothing.
  - A push and a pop in the same cycle leave the count unchanged.
  - FLUSH empties the FIFO every cycle it is present.
- Readback (`out`, zero-extended):
  - GET_PENDING: remaining.
  - GET_DATA: head data.
  - GET_ID: head ID.
  - GET_VALID: count != 0.
  - GET_COUNT: occupancy.
  - Head fields read 0 when the FIFO is empty.
  - All other codes read 0.

## Timing
- Reset values: msValid 0, smTaken 1, msAddress 0, msData 0, msID 0, msWrite 0, remaining 0, FIFO empty, auto-increment 0.
- `out` reflects the current cycle's `in` and the registered state, with zero latency.
- A start on cycle t gives msValid = 1 at t+1.
- A handshake on cycle t gives the next request, or msValid = 0, at t+1.
- msValid never deasserts without a handshake, except on reset.
- A response pushed at cycle t is visible to GET_VALID and GET_COUNT at t+1.
- A CLEAR at t exposes the new head at t+1.
- Full FIFO: smTaken = 0 the same cycle count reaches RESP_DEPTH.
- Reset mid-burst aborts the burst: msValid = 0 on the next cycle and any queued responses are discarded.

## Test plan
- SEND, single read: registers set to addr 0x00123456, id 5, write 0; SEND held 4 cycles; msTaken high on the 2nd cycle of msValid -> exactly one handshake; smValid with data 0xABCDEF, id 5 -> GET_VALID = 1, GET_DATA = 0xABCDEF, GET_ID = 5; CLEAR -> GET_VALID = 0.
- Burst with wrap: addr 0x000000FF_FFFFFE, id 0xFE, BURST count 3, msTaken always 1 -> msValid high 3 consecutive cycles; addresses ...FFFE, ...FFFF, 0x00000100_000000 (wrap into the upper field); IDs 0xFE, 0xFF, 0x00; GET_PENDING reads 3, 2, 1, 0.
- Stalls: BURST 2 with msTaken low 5 cycles -> msValid held with a stable address. ADDRESS_LOWER issued mid-burst -> ignored. SEND mid-burst -> ignored.
- FIFO full (RESP_DEPTH 4): 5 responses offered back-to-back -> 4 accepted, smTaken = 0 with the 5th held. One CLEAR -> 5th accepted next cycle; GET_COUNT = 4.
- Simultaneous events: CLEAR edge with a push in the same cycle and count 2 -> count stays 2 and the head advances. FLUSH held with smValid high -> smTaken = 0 and count = 0.
- Reset mid-burst: BURST 10, reset after 3 handshakes -> msValid = 0, GET_PENDING = 0, GET_COUNT = 0 the cycle after reset.
